// File: rtl/root_job_driver.sv
// root_job_driver
// Sequencer in front of a root composition block. It accepts one operand
// triple over valid/ready and holds it on R_IN0..R_IN2. It then pulses R_ST for
// one cycle, waits for R_RD, captures R_RES, and offers the result downstream
// over valid/ready together with the ST-to-capture cycle count.
//
// Build option: define ROOT_DRV_TIMEOUT_EN to enable the watchdog. A run that
// reaches TMO cycles without R_RD is aborted with OUT_ERR=1. Without the
// option, OUT_ERR is tied to 0 and TMO only gets a range check.
//
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   IN_VALID/IN_READY   operand handshake; A0..A2 are captured on accept
//   R_ST                one-cycle start pulse to the root
//   R_IN0..R_IN2        operands to the root, held until the next accept
//   R_RD, R_RES         root done flag and result
//   OUT_VALID/OUT_READY result handshake
//   OUT_RES, OUT_CYC    captured result; cycles from ST (saturating)
//   OUT_ERR             run aborted by the watchdog
//
// state | meaning
// IDLE  | ready for a new operand triple
// START | R_ST high for this single cycle
// ARM   | R_RD ignored, it may still be high from the previous run
// WAIT  | waiting for R_RD (or the watchdog)
// DONE  | result offered downstream
module root_job_driver #(
    parameter int W   = 16,
    parameter int TMO = 4096
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] A0,
    input  logic [W-1:0] A1,
    input  logic [W-1:0] A2,
    output logic         R_ST,
    output logic [W-1:0] R_IN0,
    output logic [W-1:0] R_IN1,
    output logic [W-1:0] R_IN2,
    input  logic         R_RD,
    input  logic [W-1:0] R_RES,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] OUT_RES,
    output logic [15:0]  OUT_CYC,
    output logic         OUT_ERR
);

    typedef enum logic [2:0] {IDLE, START, ARM, WAIT, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] in0_q, in1_q, in2_q;
    logic [W-1:0] in0_d, in1_d, in2_d;
    logic         st_q, st_d;
    logic         valid_q, valid_d;
    logic [15:0]  cnt_q, cnt_d, cnt_inc;
    logic [W-1:0] res_q, res_d;
    logic [15:0]  cyc_q, cyc_d;

    // The limit is compared against the 16-bit cycle counter, and the earliest
    // WAIT cycle already sees a count of 3.
    if (TMO < 3 || TMO > 65535) begin : g_tmo_range
        $error("root_job_driver: TMO must lie in 3..65535");
    end

`ifdef ROOT_DRV_TIMEOUT_EN
    localparam logic [15:0] TMO_CNT = 16'(TMO);
    logic err_q, err_d;
`endif

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cyc_d   = cyc_q;
`ifdef ROOT_DRV_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    in0_d   = A0;
                    in1_d   = A1;
                    in2_d   = A2;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = 16'd1;
                state_d = ARM;
            end
            ARM: begin
                cnt_d   = cnt_inc;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // A result arriving on the watchdog cycle takes priority.
                if (R_RD) begin
                    res_d   = R_RES;
                    cyc_d   = cnt_inc;
`ifdef ROOT_DRV_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = DONE;
                end
`ifdef ROOT_DRV_TIMEOUT_EN
                else if (cnt_inc >= TMO_CNT) begin
                    res_d   = '0;
                    cyc_d   = TMO_CNT;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // R_ST and OUT_VALID are registered decodes of the next state.
        st_d    = (state_d == START);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            in0_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            st_q    <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cyc_q   <= '0;
`ifdef ROOT_DRV_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            st_q    <= st_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cyc_q   <= cyc_d;
`ifdef ROOT_DRV_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // IN_READY is held low during the reset cycle even when the state is IDLE.
    assign IN_READY  = (state_q == IDLE) && !RST;
    assign R_ST      = st_q;
    assign R_IN0     = in0_q;
    assign R_IN1     = in1_q;
    assign R_IN2     = in2_q;
    assign OUT_VALID = valid_q;
    assign OUT_RES   = res_q;
    assign OUT_CYC   = cyc_q;
`ifdef ROOT_DRV_TIMEOUT_EN
    assign OUT_ERR   = err_q;
`else
    assign OUT_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_root_job_driver.sv
// Testbench for root_job_driver, including a behavioural root model.
// The root model samples ST, computes RES = IN0+IN1+IN2 and raises RD after a
// programmable latency L. With latency L, RD is visible L-1 cycles after the
// ST cycle, so the driver reports OUT_CYC = L.
module tb_root_job_driver;

`ifdef ROOT_DRV_TIMEOUT_EN
    localparam int TB_TMO = 20;
`else
    localparam int TB_TMO = 4096;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [15:0] A0 = '0, A1 = '0, A2 = '0;
    logic        IN_READY, R_ST, R_RD, OUT_VALID, OUT_ERR;
    logic [15:0] R_IN0, R_IN1, R_IN2, R_RES, OUT_RES, OUT_CYC;

    int n_checks = 0;
    int n_errors = 0;

    root_job_driver #(.W(16), .TMO(TB_TMO)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A0(A0), .A1(A1), .A2(A2), .R_ST(R_ST),
        .R_IN0(R_IN0), .R_IN1(R_IN1), .R_IN2(R_IN2),
        .R_RD(R_RD), .R_RES(R_RES), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RES(OUT_RES), .OUT_CYC(OUT_CYC), .OUT_ERR(OUT_ERR)
    );

    always #5 CLK = ~CLK;

    // root model and ST monitor
    int          cyc = 0;
    int          model_lat = 5;
    bit          stale_mode = 0;
    bit          never_rd = 0;
    int          st_count = 0;
    int          st_cyc = -1;
    logic        m_rd = 1'b0;
    logic [15:0] m_res = '0;
    logic [15:0] m_sum = '0;
    int          m_rem = 0;
    bit          m_drop = 0;

    assign R_RD  = m_rd;
    assign R_RES = m_res;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) begin
            m_rd <= 1'b0; m_res <= '0; m_rem <= 0; m_drop <= 0;
        end else begin
            if (m_drop) begin
                m_rd <= 1'b0; m_drop <= 0;
            end
            if (R_ST) begin
                st_count <= st_count + 1;
                st_cyc   <= cyc;
                m_sum    <= 16'(R_IN0 + R_IN1 + R_IN2);
                m_rem    <= never_rd ? 0 : model_lat - 2;
                if (stale_mode) m_drop <= 1;
                else            m_rd <= 1'b0;
            end else if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_rd <= 1'b1; m_res <= m_sum;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout got stuck want finish");
        $fatal(1, "simulation time limit");
    end

    // Offer one triple, wait for the accept, then wait for OUT_VALID.
    task automatic run_job(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                           input int budget, output int acc, output int vcyc,
                           output bit got_valid, output bit stable);
        int n;
        IN_VALID = 1'b1; A0 = a0; A1 = a1; A2 = a2;
        n = 0;
        while (!IN_READY && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        acc = cyc;
        stable = 1;
        n = 0;
        while (!OUT_VALID && n < budget) begin
            if (R_IN0 !== a0 || R_IN1 !== a1 || R_IN2 !== a2) stable = 0;
            @(posedge CLK); #1; n++;
        end
        if (R_IN0 !== a0 || R_IN1 !== a1 || R_IN2 !== a2) stable = 0;
        got_valid = OUT_VALID;
        vcyc = cyc;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (IN_READY !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %0b want 0", IN_READY); end
        n_checks++;
        if ({R_ST, OUT_VALID, OUT_ERR} !== 3'b000 || R_IN0 !== 0 || R_IN1 !== 0 || R_IN2 !== 0 ||
            OUT_RES !== 0 || OUT_CYC !== 0) begin
            n_errors++;
            $display("FAIL reset_outputs got st=%0b v=%0b e=%0b in=%0d/%0d/%0d res=%0d cyc=%0d want all 0",
                     R_ST, OUT_VALID, OUT_ERR, R_IN0, R_IN1, R_IN2, OUT_RES, OUT_CYC);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (IN_READY !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready got %0b want 1", IN_READY); end
    endtask

    task automatic test_single();
        int acc, vc, st0;
        bit gv, stb;
        stale_mode = 0; never_rd = 0; model_lat = 5; OUT_READY = 1'b1;
        st0 = st_count;
        run_job(16'd1, 16'd2, 16'd3, 40, acc, vc, gv, stb);
        n_checks++;
        if (gv !== 1'b1) begin n_errors++; $display("FAIL single_valid got %0b want 1", gv); end
        n_checks++;
        if (OUT_RES !== 16'd6) begin n_errors++; $display("FAIL single_res got %0d want 6", OUT_RES); end
        n_checks++;
        if (OUT_CYC !== 16'd5) begin n_errors++; $display("FAIL single_cyc got %0d want 5", OUT_CYC); end
        n_checks++;
        if (OUT_ERR !== 1'b0) begin n_errors++; $display("FAIL single_err got %0b want 0", OUT_ERR); end
        n_checks++;
        if (vc - acc != 5) begin n_errors++; $display("FAIL single_latency got %0d want 5", vc - acc); end
        n_checks++;
        if (st_count - st0 != 1 || st_cyc != acc) begin
            n_errors++;
            $display("FAIL single_st_pulse got count=%0d at=%0d want count=1 at=%0d", st_count - st0, st_cyc, acc);
        end
        n_checks++;
        if (stb !== 1'b1) begin n_errors++; $display("FAIL single_rin_stable got %0b want 1", stb); end
        @(posedge CLK); #1;
        n_checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            n_errors++; $display("FAIL single_done_one_cycle got v=%0b rdy=%0b want v=0 rdy=1", OUT_VALID, IN_READY);
        end
    endtask

    task automatic test_stale();
        int acc, vc;
        bit gv, stb;
        stale_mode = 1; model_lat = 5; OUT_READY = 1'b1;
        run_job(16'd10, 16'd20, 16'd30, 40, acc, vc, gv, stb);
        n_checks++;
        if (gv !== 1'b1 || OUT_RES !== 16'd60) begin
            n_errors++; $display("FAIL stale_res got v=%0b res=%0d want v=1 res=60", gv, OUT_RES);
        end
        n_checks++;
        if (OUT_CYC !== 16'd5) begin n_errors++; $display("FAIL stale_cyc got %0d want 5", OUT_CYC); end
        @(posedge CLK); #1;
        stale_mode = 0;
    endtask

    task automatic test_backpressure();
        int acc, vc, lat;
        bit gv, stb, hold_ok;
        logic [15:0] a0, a1, a2, exp_res, r0, c0;
        a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        exp_res = 16'(a0 + a1 + a2);
        lat = int'($urandom_range(3, 9));
        model_lat = lat; OUT_READY = 1'b0;
        run_job(a0, a1, a2, 40, acc, vc, gv, stb);
        n_checks++;
        if (gv !== 1'b1 || OUT_RES !== exp_res || OUT_CYC !== 16'(lat)) begin
            n_errors++;
            $display("FAIL bp_result got v=%0b res=%0d cyc=%0d want v=1 res=%0d cyc=%0d", gv, OUT_RES, OUT_CYC, exp_res, lat);
        end
        r0 = exp_res; c0 = 16'(lat);
        hold_ok = 1;
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID !== 1'b1 || OUT_RES !== r0 || OUT_CYC !== c0 || IN_READY !== 1'b0) hold_ok = 0;
        end
        n_checks++;
        if (!hold_ok) begin
            n_errors++;
            $display("FAIL bp_hold got v=%0b res=%0d cyc=%0d rdy=%0b want v=1 res=%0d cyc=%0d rdy=0",
                     OUT_VALID, OUT_RES, OUT_CYC, IN_READY, r0, c0);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            n_errors++; $display("FAIL bp_release got rdy=%0b v=%0b want rdy=1 v=0", IN_READY, OUT_VALID);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops [4][3];
        logic [15:0] exp_q[$];
        logic [15:0] got_res [4];
        logic [15:0] got_cyc [4];
        int acc_c [4];
        int k, nres;
        bit acc_now;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) ops[i][j] = 16'($urandom);
            exp_q.push_back(16'(ops[i][0] + ops[i][1] + ops[i][2]));
            acc_c[i] = 0; got_res[i] = '0; got_cyc[i] = '0;
        end
        model_lat = 3; OUT_READY = 1'b1;
        k = 0; nres = 0;
        A0 = ops[0][0]; A1 = ops[0][1]; A2 = ops[0][2]; IN_VALID = 1'b1;
        for (int c = 0; c < 60 && nres < 4; c++) begin
            acc_now = IN_READY && IN_VALID;
            if (OUT_VALID) begin
                got_res[nres] = OUT_RES; got_cyc[nres] = OUT_CYC; nres++;
            end
            @(posedge CLK); #1;
            if (acc_now) begin
                acc_c[k] = cyc; k++;
                if (k < 4) begin A0 = ops[k][0]; A1 = ops[k][1]; A2 = ops[k][2]; end
                else IN_VALID = 1'b0;
            end
        end
        IN_VALID = 1'b0;
        n_checks++;
        if (nres != 4) begin n_errors++; $display("FAIL b2b_count got %0d want 4", nres); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_res[i] !== exp_q[i] || got_cyc[i] !== 16'd3) begin
                n_errors++;
                $display("FAIL b2b_result[%0d] got res=%0d cyc=%0d want res=%0d cyc=3", i, got_res[i], got_cyc[i], exp_q[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (acc_c[i] - acc_c[i-1] != 5) begin
                    n_errors++; $display("FAIL b2b_period[%0d] got %0d want 5", i, acc_c[i] - acc_c[i-1]);
                end
            end
        end
        repeat (2) @(posedge CLK); #1;
    endtask

    task automatic test_random();
        int acc, vc, lat, d;
        bit gv, stb, hold_ok;
        logic [15:0] a0, a1, a2, exp_res;
        for (int it = 0; it < 6; it++) begin
            a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
            exp_res = 16'(a0 + a1 + a2);
            lat = int'($urandom_range(3, 12));
            d = int'($urandom_range(0, 3));
            model_lat = lat; OUT_READY = 1'b0;
            run_job(a0, a1, a2, 40, acc, vc, gv, stb);
            n_checks++;
            if (gv !== 1'b1 || OUT_RES !== exp_res || OUT_CYC !== 16'(lat) || OUT_ERR !== 1'b0 ||
                vc - acc != lat || stb !== 1'b1) begin
                n_errors++;
                $display("FAIL rand_job[%0d] got v=%0b res=%0d cyc=%0d err=%0b lat=%0d stable=%0b want v=1 res=%0d cyc=%0d err=0 lat=%0d stable=1",
                         it, gv, OUT_RES, OUT_CYC, OUT_ERR, vc - acc, stb, exp_res, lat, lat);
            end
            hold_ok = 1;
            for (int i = 0; i < d; i++) begin
                @(posedge CLK); #1;
                if (OUT_VALID !== 1'b1 || OUT_RES !== exp_res || IN_READY !== 1'b0) hold_ok = 0;
            end
            OUT_READY = 1'b1;
            @(posedge CLK); #1;
            n_checks++;
            if (!hold_ok || OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
                n_errors++;
                $display("FAIL rand_drain[%0d] got hold=%0b v=%0b rdy=%0b want hold=1 v=0 rdy=1", it, hold_ok, OUT_VALID, IN_READY);
            end
        end
    endtask

`ifdef ROOT_DRV_TIMEOUT_EN
    task automatic test_timeout();
        int acc, vc;
        bit gv, stb;
        OUT_READY = 1'b1;
        never_rd = 1;
        run_job(16'd7, 16'd8, 16'd9, 60, acc, vc, gv, stb);
        n_checks++;
        if (gv !== 1'b1 || OUT_ERR !== 1'b1 || OUT_RES !== 16'd0 || OUT_CYC !== 16'd20 || vc - acc != 20) begin
            n_errors++;
            $display("FAIL tmo_abort got v=%0b err=%0b res=%0d cyc=%0d lat=%0d want v=1 err=1 res=0 cyc=20 lat=20",
                     gv, OUT_ERR, OUT_RES, OUT_CYC, vc - acc);
        end
        @(posedge CLK); #1;
        never_rd = 0;
        model_lat = 20;
        run_job(16'd100, 16'd200, 16'd300, 60, acc, vc, gv, stb);
        n_checks++;
        if (gv !== 1'b1 || OUT_ERR !== 1'b0 || OUT_RES !== 16'd600 || OUT_CYC !== 16'd20) begin
            n_errors++;
            $display("FAIL tmo_result_wins got v=%0b err=%0b res=%0d cyc=%0d want v=1 err=0 res=600 cyc=20",
                     gv, OUT_ERR, OUT_RES, OUT_CYC);
        end
        @(posedge CLK); #1;
        model_lat = 21;
        run_job(16'd1, 16'd1, 16'd1, 60, acc, vc, gv, stb);
        n_checks++;
        if (gv !== 1'b1 || OUT_ERR !== 1'b1 || OUT_RES !== 16'd0 || OUT_CYC !== 16'd20) begin
            n_errors++;
            $display("FAIL tmo_late_rd got v=%0b err=%0b res=%0d cyc=%0d want v=1 err=1 res=0 cyc=20",
                     gv, OUT_ERR, OUT_RES, OUT_CYC);
        end
        repeat (3) @(posedge CLK); #1;
    endtask
`endif

    task automatic test_reset_in_wait();
        int acc, vc, n;
        bit gv, stb;
        model_lat = 30; OUT_READY = 1'b1;
        IN_VALID = 1'b1; A0 = 16'd55; A1 = 16'd66; A2 = 16'd77;
        n = 0;
        while (!IN_READY && n < 20) begin @(posedge CLK); #1; n++; end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        n_checks++;
        if (OUT_VALID !== 1'b0 || R_IN0 !== 16'd55) begin
            n_errors++; $display("FAIL rstw_pre got v=%0b in0=%0d want v=0 in0=55", OUT_VALID, R_IN0);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if ({IN_READY, R_ST, OUT_VALID, OUT_ERR} !== 4'b0000 || R_IN0 !== 0 || R_IN1 !== 0 || R_IN2 !== 0 ||
            OUT_RES !== 0 || OUT_CYC !== 0) begin
            n_errors++;
            $display("FAIL rstw_outputs got rdy=%0b st=%0b v=%0b e=%0b in=%0d/%0d/%0d res=%0d cyc=%0d want all 0",
                     IN_READY, R_ST, OUT_VALID, OUT_ERR, R_IN0, R_IN1, R_IN2, OUT_RES, OUT_CYC);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            n_errors++; $display("FAIL rstw_idle got rdy=%0b v=%0b want rdy=1 v=0", IN_READY, OUT_VALID);
        end
        model_lat = 5;
        run_job(16'd4, 16'd4, 16'd4, 40, acc, vc, gv, stb);
        n_checks++;
        if (gv !== 1'b1 || OUT_RES !== 16'd12 || OUT_CYC !== 16'd5) begin
            n_errors++; $display("FAIL rstw_next_job got v=%0b res=%0d cyc=%0d want v=1 res=12 cyc=5", gv, OUT_RES, OUT_CYC);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef ROOT_DRV_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
